dmem_responder: RTL and testbench

//   Data-memory responder at the far end of the pipeline's memory-access interface.

---
 rtl/dmem_responder.sv | 83 ++++++++
 tb/tb_dmem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding RV32I load/store responder with programmable latency
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              accept, fire, oor, illegal, misalign, err;
  logic [1:0]        off, size;
  logic [4:0]        sh;
  logic [31:0]       rd_word, sh_word, ld_data, wmask, st_word;
  assign req_ready = state_q == IDLE;
  assign accept    = req_ready && req_valid;
  always_comb begin
    fire    = state_q == BUSY && cnt_q == 4'd0;
    state_d = accept ? BUSY : fire ? IDLE : state_q;
    cnt_d   = accept ? CNT_INIT : (state_q == BUSY && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  end
  always_comb begin
    off      = addr_q[1:0];
    size     = f3_q[1:0];
    oor      = {1'b0, addr_q[ADDR_W-1:2]} >= DEPTH_L;
    illegal  = we_q ? f3_q > 3'd2 : (size == 2'd3 || f3_q > 3'd5);
    misalign = (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
    err      = illegal || misalign || oor;
    sh       = size == 2'd0 ? {off, 3'b000} : size == 2'd1 ? {off[1], 4'b0000} : 5'd0;
    rd_word  = mem[addr_q[AW+1:2]];
    sh_word  = rd_word >> sh;
    ld_data  = size == 2'd0 ? {{24{~f3_q[2] & sh_word[7]}}, sh_word[7:0]} :
               size == 2'd1 ? {{16{~f3_q[2] & sh_word[15]}}, sh_word[15:0]} : rd_word;
    wmask    = (size == 2'd0 ? 32'h0000_00ff : size == 2'd1 ? 32'h0000_ffff : 32'hffff_ffff) << sh;
    st_word  = (rd_word & ~wmask) | ((wdata_q << sh) & wmask);
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= accept ? req_we : we_q;
      addr_q    <= accept ? req_addr : addr_q;
      f3_q      <= accept ? req_funct3 : f3_q;
      wdata_q   <= accept ? req_wdata : wdata_q;
      rsp_valid <= fire;
      rsp_err   <= fire && err;
      rsp_rdata <= (fire && !err && !we_q) ? ld_data : '0;
    end
  end
  // state is forced to IDLE during reset, so an aborted store never reaches this write
  always_ff @(posedge clk) begin
    if (fire && we_q && !err) mem[addr_q[AW+1:2]] <= st_word;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed checks of three latency variants against a byte-array model
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LATS [3] = '{1, 3, 4};
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we [3];
  logic [31:0] req_addr [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err [3];
  logic [7:0]  mb [3][DEPTH*4];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] rd, er, a;
  logic        e, ee;
  logic [31:0] qd [$];
  logic        qe [$];
  int          acc, sent;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LATS[g])) u_dut (
      .clk(clk), .arst_n(arst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_funct3(req_funct3[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model(input int d, input bit we, input logic [31:0] ad, input logic [2:0] f,
                       input logic [31:0] wd, output logic [31:0] r, output logic x);
    int n;
    n = f[1:0] == 2'd0 ? 1 : f[1:0] == 2'd1 ? 2 : 4;
    x = (we ? f > 3'd2 : (f == 3'd3 || f > 3'd5)) || (ad % n != 0) || (ad / 4 >= DEPTH);
    r = '0;
    if (!x) begin
      if (we) for (int i = 0; i < n; i++) mb[d][ad+i] = wd[8*i +: 8];
      else begin
        for (int i = 0; i < n; i++) r[8*i +: 8] = mb[d][ad+i];
        if (!f[2] && n < 4 && r[8*n-1]) r |= ~((32'h1 << (8*n)) - 32'h1);
      end
    end
  endtask
  task automatic xact(input int d, input bit we, input logic [31:0] ad, input logic [2:0] f,
                      input logic [31:0] wd, output logic [31:0] r, output logic x);
    logic [31:0] mr;
    logic        mx;
    int          k;
    model(d, we, ad, f, wd, mr, mx);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = ad; req_funct3[d] = f; req_wdata[d] = wd;
    k = 0;
    while (!req_ready[d] && k < 20) begin @(negedge clk); k++; end
    chk("ready", 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1 req_valid[d] = 1'b0;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!rsp_valid[d] && k < LATS[d] + 5);
    chk("latency", k, LATS[d]);
    chk("rdata", rsp_rdata[d], mr);
    chk("err", 32'(rsp_err[d]), 32'(mx));
    r = rsp_rdata[d];
    x = rsp_err[d];
    @(posedge clk); #1 chk("pulse", 32'(rsp_valid[d]), 32'd0);
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_funct3[d] = '0; req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'd0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
    end
    @(negedge clk) arst_n = 1'b1;
    #1 for (int d = 0; d < 3; d++) chk("rst_ready", 32'(req_ready[d]), 32'd1);
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++) xact(d, 1'b1, 32'(w*4), 3'd2, $urandom, rd, e);
    xact(0, 1'b1, 32'h10, 3'd2, 32'hdeadbeef, rd, e);
    chk("sw_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h10, 3'd2, 32'd0, rd, e);
    chk("lw_10", rd, 32'hdeadbeef);
    xact(0, 1'b1, 32'h20, 3'd2, 32'h11223344, rd, e);
    xact(0, 1'b1, 32'h21, 3'd0, 32'h00000080, rd, e);
    xact(0, 1'b0, 32'h21, 3'd0, 32'd0, rd, e);
    chk("lb_21", rd, 32'hffffff80);
    xact(0, 1'b0, 32'h21, 3'd4, 32'd0, rd, e);
    chk("lbu_21", rd, 32'h00000080);
    xact(0, 1'b0, 32'h20, 3'd2, 32'd0, rd, e);
    chk("lw_20", rd, 32'h11228044);
    xact(0, 1'b0, 32'h13, 3'd1, 32'd0, rd, e);
    chk("lh_13_err", 32'(e), 32'd1);
    xact(0, 1'b1, 32'h12, 3'd2, 32'h55555555, rd, e);
    chk("sw_12_err", 32'(e), 32'd1);
    xact(0, 1'b0, 32'h10, 3'd2, 32'd0, rd, e);
    chk("lw_10_kept", rd, 32'hdeadbeef);
    xact(0, 1'b0, 32'h10, 3'd3, 32'd0, rd, e);
    chk("f3_011_err", 32'(e), 32'd1);
    xact(0, 1'b1, 32'(DEPTH*4), 3'd2, 32'hcafef00d, rd, e);
    chk("oor_sw_err", 32'(e), 32'd1);
    xact(0, 1'b0, 32'(DEPTH*4), 3'd2, 32'd0, rd, e);
    chk("oor_lw_err", 32'(e), 32'd1);
    xact(0, 1'b0, 32'h0, 3'd2, 32'd0, rd, e);
    for (int d = 0; d < 3; d++)
      for (int n = 0; n < 40; n++) begin
        a = $urandom_range(0, 7) == 0 ? 32'(DEPTH*4 + $urandom_range(0, 15)) : 32'($urandom_range(0, 63));
        xact(d, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom, rd, e);
      end
    acc = -100;
    sent = 0;
    req_valid[2] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("tp_ready", 32'(req_ready[2]), 32'(c >= acc + 5));
      if (c >= acc + 5) begin
        if (sent < 4) begin
          req_we[2] = 1'($urandom_range(0, 1));
          req_addr[2] = 32'($urandom_range(0, 15) * 4);
          req_funct3[2] = 3'($urandom_range(0, 2));
          req_wdata[2] = $urandom;
          model(2, req_we[2], req_addr[2], req_funct3[2], req_wdata[2], er, ee);
          qd.push_back(er);
          qe.push_back(ee);
          acc = c;
          sent++;
        end else req_valid[2] = 1'b0;
      end else begin
        req_we[2] = 1'b1;
        req_addr[2] = 32'($urandom_range(0, 63));
        req_funct3[2] = 3'($urandom_range(0, 7));
        req_wdata[2] = $urandom;
      end
      @(posedge clk); #1;
      chk("tp_rsp", 32'(rsp_valid[2]), 32'(c == acc + 4));
      if (c == acc + 4 && qd.size() > 0) begin
        chk("tp_rdata", rsp_rdata[2], qd.pop_front());
        chk("tp_err", 32'(rsp_err[2]), 32'(qe.pop_front()));
      end
    end
    req_valid[2] = 1'b0;
    xact(1, 1'b1, 32'h30, 3'd2, 32'h0badf00d, rd, e);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h30; req_funct3[1] = 3'd2; req_wdata[1] = 32'h12345678;
    chk("ab_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("ab_busy", 32'(req_ready[1]), 32'd0);
    arst_n = 1'b0;
    #1 chk("ab_idle", 32'(req_ready[1]), 32'd1);
    @(negedge clk) arst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1 chk("ab_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    xact(1, 1'b0, 32'h30, 3'd2, 32'd0, rd, e);
    chk("ab_lw_30", rd, 32'h0badf00d);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end
endmodule
